// File: rtl/team_06_pwm_out.sv
// PWM output stage with sample-rate pacing and soft-start ramp to midscale.
// Optional TEAM06_PWM_CLIP_EN adds a saturating clip_cnt of full-scale samples.
`timescale 1ns/1ps

module team_06_pwm_out #(
  parameter int unsigned PWM_REPEAT = 4,
  parameter int unsigned RAMP_STEP  = 8
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       en,
  input  logic [7:0] audio_in,
  output logic       pwm_o,
  output logic       finished,
  output logic       running
`ifdef TEAM06_PWM_CLIP_EN
  ,
  output logic [15:0] clip_cnt
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RAMP = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  localparam logic [3:0] REP_LAST = 4'(PWM_REPEAT - 1);
  localparam logic [8:0] STEP9    = 9'(RAMP_STEP);

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] rep_q, rep_d;
  logic [7:0] duty_q, duty_d;
  logic [7:0] ramp_q, ramp_d;
  logic       pwm_q, pwm_d;
  logic       fin_q, fin_d;
  logic       per_end;
  logic [8:0] ramp_sum;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rep_d    = rep_q;
    duty_d   = duty_q;
    ramp_d   = ramp_q;
    per_end  = (cnt_q == 8'hFF) && (rep_q == REP_LAST);
    ramp_sum = {1'b0, ramp_q} + STEP9;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
      rep_d   = 4'd0;
      duty_d  = 8'd0;
      ramp_d  = 8'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = RAMP;
          cnt_d   = 8'd0;
          rep_d   = 4'd0;
          duty_d  = 8'd0;
          ramp_d  = 8'd0;
        end
        RAMP, RUN: begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'hFF) begin
            rep_d = (rep_q == REP_LAST) ? 4'd0 : rep_q + 4'd1;
          end
          // duty only moves on the sample boundary
          if (per_end) begin
            if (state_q == RUN) begin
              duty_d = audio_in;
            end else if (ramp_sum >= 9'd128) begin
              duty_d  = 8'd128;
              ramp_d  = 8'd128;
              state_d = RUN;
            end else begin
              ramp_d = ramp_sum[7:0];
              duty_d = ramp_sum[7:0];
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    pwm_d = en && (state_q != IDLE) && (cnt_q < duty_q);
    fin_d = (state_d != IDLE) && (cnt_d == 8'd0) && (rep_d == 4'd0);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      rep_q   <= 4'd0;
      duty_q  <= 8'd0;
      ramp_q  <= 8'd0;
      pwm_q   <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      duty_q  <= duty_d;
      ramp_q  <= ramp_d;
      pwm_q   <= pwm_d;
      fin_q   <= fin_d;
    end
  end

  assign pwm_o    = pwm_q;
  assign finished = fin_q;
  assign running  = (state_q == RUN);

`ifdef TEAM06_PWM_CLIP_EN
  logic [15:0] clip_q, clip_d;
  logic        clip_hit;

  always_comb begin
    clip_d   = clip_q;
    clip_hit = (state_q == RUN) && per_end &&
               ((audio_in == 8'h00) || (audio_in == 8'hFF));
    if (!en) begin
      clip_d = 16'd0;
    end else if (clip_hit && (clip_q != 16'hFFFF)) begin
      clip_d = clip_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      clip_q <= 16'd0;
    end else begin
      clip_q <= clip_d;
    end
  end

  assign clip_cnt = clip_q;
`endif

endmodule
